// File: rtl/apple_gen_scan.sv
// rtl/apple_gen_scan.sv - apple placer: LFSR start cell, raster scan of the occupancy map
module apple_gen_scan #(
    parameter int                COORD_W   = 6,
    parameter int                WIDTH     = 40,
    parameter int                HEIGHT    = 30,
    parameter int                NUM_EXCL  = 2,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                         clk_25M,
    input  logic                         rst,
    input  logic                         req,
    input  logic [NUM_EXCL*COORD_W-1:0]  excl_x,
    input  logic [NUM_EXCL*COORD_W-1:0]  excl_y,
    output logic [COORD_W-1:0]           rd_x,
    output logic [COORD_W-1:0]           rd_y,
    input  logic                         rd_data,
    output logic                         busy,
    output logic                         done,
    output logic                         fail,
    output logic [COORD_W-1:0]           apple_x,
    output logic [COORD_W-1:0]           apple_y
);
    localparam int CELLS = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(CELLS + 1);
    localparam logic [CNT_W-1:0]   CELLS_C = CNT_W'(CELLS);
    localparam logic [CNT_W-1:0]   LAST_C  = CNT_W'(CELLS - 1);
    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(HEIGHT - 1);
    // Right-shifting Galois feedback masks for maximal-length sequences
    localparam logic [63:0] TAPS64 = (LFSR_W == 12) ? 64'h0000_0E08 :
                                     (LFSR_W == 20) ? 64'h0009_0000 :
                                     (LFSR_W == 24) ? 64'h00E1_0000 :
                                     (LFSR_W == 32) ? 64'hA300_0000 : 64'h0000_B400;
    localparam logic [LFSR_W-1:0] TAPS = TAPS64[LFSR_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t              r_state;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [COORD_W-1:0]  r_rd_x, r_rd_y;
    logic [COORD_W-1:0]  r_d_x, r_d_y;
    logic                r_d_vld, r_rd_new;
    logic [CNT_W-1:0]    r_issued, r_checked;
    logic                r_busy, r_done, r_fail;
    logic [COORD_W-1:0]  r_apple_x, r_apple_y;

    logic [COORD_W-1:0]  w_sx_raw, w_sy_raw, w_sx, w_sy;
    logic [COORD_W-1:0]  w_nx, w_ny;
    logic                w_excl, w_hit;

    always_comb begin
        w_sx_raw = r_lfsr[COORD_W-1:0];
        w_sy_raw = r_lfsr[2*COORD_W-1:COORD_W];
        w_sx = ({1'b0, w_sx_raw} >= (COORD_W+1)'(WIDTH))  ? w_sx_raw - COORD_W'(WIDTH)  : w_sx_raw;
        w_sy = ({1'b0, w_sy_raw} >= (COORD_W+1)'(HEIGHT)) ? w_sy_raw - COORD_W'(HEIGHT) : w_sy_raw;
    end

    always_comb begin
        w_nx = r_rd_x + COORD_W'(1);
        w_ny = r_rd_y;
        if (r_rd_x == X_LAST) begin
            w_nx = '0;
            w_ny = (r_rd_y == Y_LAST) ? '0 : r_rd_y + COORD_W'(1);
        end
    end

    // Exclusion needs both coordinates of the same entry to match
    always_comb begin
        w_excl = 1'b0;
        for (int i = 0; i < NUM_EXCL; i++) begin
            if (excl_x[i*COORD_W +: COORD_W] == r_d_x && excl_y[i*COORD_W +: COORD_W] == r_d_y)
                w_excl = 1'b1;
        end
        w_hit = r_d_vld && !rd_data && !w_excl;
    end

    always_ff @(posedge clk_25M) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_rd_x    <= '0;
            r_rd_y    <= '0;
            r_d_x     <= '0;
            r_d_y     <= '0;
            r_d_vld   <= 1'b0;
            r_rd_new  <= 1'b0;
            r_issued  <= '0;
            r_checked <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
            r_apple_x <= '0;
            r_apple_y <= '0;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_rd_x    <= w_sx;
                        r_rd_y    <= w_sy;
                        r_issued  <= CNT_W'(1);
                        r_checked <= '0;
                        r_rd_new  <= 1'b1;
                        r_d_vld   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // rd_data now answers the address issued last cycle; move it to the check stage
                    r_d_x   <= r_rd_x;
                    r_d_y   <= r_rd_y;
                    r_d_vld <= r_rd_new;
                    if (r_issued < CELLS_C) begin
                        r_rd_x   <= w_nx;
                        r_rd_y   <= w_ny;
                        r_issued <= r_issued + CNT_W'(1);
                        r_rd_new <= 1'b1;
                    end else begin
                        r_rd_new <= 1'b0;
                    end
                    if (r_d_vld) begin
                        r_checked <= r_checked + CNT_W'(1);
                        if (w_hit) begin
                            r_apple_x <= r_d_x;
                            r_apple_y <= r_d_y;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (r_checked == LAST_C) begin
                            r_fail  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_fail  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_x    = r_rd_x;
    assign rd_y    = r_rd_y;
    assign busy    = r_busy;
    assign done    = r_done;
    assign fail    = r_fail;
    assign apple_x = r_apple_x;
    assign apple_y = r_apple_y;
endmodule

// File: tb/tb_apple_gen_scan.sv
// tb/tb_apple_gen_scan.sv - self-checking bench for apple_gen_scan
module tb_apple_gen_scan;
    localparam int W = 40, H = 30, CW = 6, NE = 2, N = W * H;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic              rst, req, rd_data;
    logic [NE*CW-1:0]  excl_x, excl_y;
    logic [CW-1:0]     rd_x, rd_y, apple_x, apple_y;
    logic              busy, done, fail;

    apple_gen_scan dut (
        .clk_25M(clk), .rst(rst), .req(req),
        .excl_x(excl_x), .excl_y(excl_y),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .busy(busy), .done(done), .fail(fail),
        .apple_x(apple_x), .apple_y(apple_y)
    );

    bit          occ [N];
    int          ex [NE];
    int          ey [NE];
    logic [15:0] m_lfsr;
    int          e_ax, e_ay;
    int          n_assert, n_fail;

    // Occupancy RAM with one cycle read latency, plus the free-running LFSR reference
    always @(posedge clk) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        if (int'(rd_x) < W && int'(rd_y) < H) rd_data <= occ[int'(rd_y) * W + int'(rd_x)];
        else                                  rd_data <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input int x0, input int y0, input int x1, input int y1);
        ex[0] = x0; ey[0] = y0; ex[1] = x1; ey[1] = y1;
        for (int i = 0; i < NE; i++) begin
            excl_x[i*CW +: CW] = CW'(ex[i]);
            excl_y[i*CW +: CW] = CW'(ey[i]);
        end
    endtask

    task automatic fill(input int pct);
        for (int i = 0; i < N; i++) occ[i] = ($urandom_range(0, 99) < pct);
    endtask

    function automatic int start_idx(input logic [15:0] l);
        int sx, sy;
        sx = int'(l) % 64;
        sy = (int'(l) / 64) % 64;
        if (sx >= W) sx -= W;
        if (sy >= H) sy -= H;
        return sy * W + sx;
    endfunction

    function automatic bit is_ex(input int x, input int y);
        for (int i = 0; i < NE; i++) if (ex[i] == x && ey[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    // Walk the board as one linear ring starting at the start cell
    task automatic predict(input int s, output int ax, output int ay, output int lat, output int f);
        f = 1; lat = N + 2; ax = e_ax; ay = e_ay;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (s + k) % N;
            if (!occ[idx] && !is_ex(idx % W, idx / W)) begin
                ax = idx % W; ay = idx / W; lat = k + 3; f = 0;
                return;
            end
        end
    endtask

    // Called #1 after a rising edge with req low; returns #1 after an edge
    task automatic run_search(input string tag, input bit hold);
        int s, ax, ay, lat, f, dc, nxt;
        s = start_idx(m_lfsr);
        predict(s, ax, ay, lat, f);
        req = 1'b1;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        chk({tag, " start_x"}, rd_x, s % W);
        chk({tag, " start_y"}, rd_y, s / W);
        chk({tag, " busy"}, busy, 1);
        dc = -1;
        for (int c = 1; c <= N + 10; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (c == 2) begin
                nxt = (s + 1) % N;
                chk({tag, " raster"}, rd_y * W + rd_x, nxt);
            end
            if (done) begin
                dc = c;
                break;
            end
        end
        chk({tag, " latency"}, dc, lat);
        chk({tag, " fail"}, fail, f);
        chk({tag, " apple_x"}, apple_x, ax);
        chk({tag, " apple_y"}, apple_y, ay);
        chk({tag, " busy_done"}, busy, 1);
        @(posedge clk); #1;
        req = 1'b0;
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " busy_off"}, busy, 0);
        repeat (2) begin
            @(posedge clk); #1;
            chk({tag, " idle"}, {busy, done}, 0);
        end
        if (f == 0) begin
            e_ax = ax; e_ay = ay;
        end
    endtask

    initial begin
        int s, nd;
        n_assert = 0; n_fail = 0; e_ax = 0; e_ay = 0;
        rst = 1'b0; req = 1'b0;
        set_ex(63, 63, 63, 63);
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst fail", fail, 0);
        chk("rst apple", {apple_x, apple_y}, 0);
        chk("rst rd", {rd_x, rd_y}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_search("empty", 1'b0);

        for (int t = 0; t < 5; t++) begin
            fill(60 + 8 * t);
            set_ex($urandom_range(0, W - 1), $urandom_range(0, H - 1),
                   $urandom_range(0, W - 1), $urandom_range(0, H - 1));
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
            run_search("random", 1'b0);
        end

        fill(0);
        s = start_idx(m_lfsr);
        occ[s] = 1'b1;
        occ[(s + 1) % N] = 1'b1;
        set_ex(((s + 2) % N) % W, ((s + 2) % N) / W, 63, 63);
        run_search("occ_excl", 1'b0);

        fill(0);
        s = start_idx(m_lfsr);
        for (int i = s; i < N; i++) occ[i] = 1'b1;
        set_ex(1, 0, 0, 1);
        run_search("wrap", 1'b0);

        fill(100);
        run_search("full", 1'b0);

        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst apple", {apple_x, apple_y}, 0);
        e_ax = 0; e_ay = 0;
        nd = 0;
        repeat (30) begin
            @(posedge clk); #1;
            nd += int'(done);
        end
        chk("midrst no_done", nd, 0);
        fill(0);
        run_search("after_rst", 1'b0);

        s = start_idx(m_lfsr);
        set_ex(s % W, (s / W + 1) % H, (s % W + 1) % W, s / W);
        run_search("hold_req", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
